// File: rtl/ssb_tx_pkg.sv
// ssb_tx_pkg: SSB grid constants, PSS/SSS m-sequences and mapper FSM states.
package ssb_tx_pkg;
   localparam int SSB_SC = 240;
   localparam int PSS_LEN = 127;
   localparam logic [7:0] PSS_START = 8'd56;
   localparam logic [8:0] N_ID_1_MAX = 9'd335;
   localparam logic [7:0] GAP0_LO = 8'd48;
   localparam logic [7:0] GAP0_HI = 8'd56;
   localparam logic [7:0] GAP1_LO = 8'd183;
   localparam logic [7:0] GAP1_HI = 8'd192;
   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_EMIT} state_t;
   function automatic logic [126:0] mseq(input logic [6:0] seed, input int tap);
      logic [126:0] x;
      x = {120'd0, seed};
      for (int i = 0; i < 120; i++) x[i+7] = x[i+tap] ^ x[i];
      return x;
   endfunction
   // bit i of each constant is x(i)
   localparam logic [126:0] X_PSS = mseq(7'b1110110, 4);
   localparam logic [126:0] X0_SSS = mseq(7'b0000001, 4);
   localparam logic [126:0] X1_SSS = mseq(7'b0000001, 1);
endpackage

// File: rtl/ssb_seq_gen.sv
// ssb_seq_gen: mod-127 index counters yielding PSS and SSS sign bits (1 means d = -1).
module ssb_seq_gen
   import ssb_tx_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic       load_i,
   input  logic       step_pss_i,
   input  logic       step_sss_i,
   input  logic [6:0] m_pss_i,
   input  logic [6:0] m0_i,
   input  logic [6:0] m1_i,
   output logic       pss_o,
   output logic       sss_o
);
   logic [6:0] i_pss, i0, i1;
   function automatic logic [6:0] inc127(input logic [6:0] v);
      return v == 7'd126 ? 7'd0 : v + 7'd1;
   endfunction
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         i_pss <= '0;
         i0 <= '0;
         i1 <= '0;
      end else if (load_i) begin
         i_pss <= m_pss_i;
         i0 <= m0_i;
         i1 <= m1_i;
      end else begin
         if (step_pss_i) i_pss <= inc127(i_pss);
         if (step_sss_i) begin
            i0 <= inc127(i0);
            i1 <= inc127(i1);
         end
      end
   end
   assign pss_o = X_PSS[i_pss];
   assign sss_o = X0_SSS[i0] ^ X1_SSS[i1];
endmodule

// File: rtl/ssb_tx_mapper.sv
// ssb_tx_mapper: SS/PBCH block RE generator; SSB_TX_PBCH_EN sources PBCH REs from s_axis_pbch, else they are zero.
module ssb_tx_mapper
   import ssb_tx_pkg::*;
#(
   parameter int IQ_DW = 16,
   parameter int FFT_LEN = 256,
   parameter int AMP = 8192
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic                 start_i,
   input  logic [8:0]           N_id_1_i,
   input  logic [1:0]           N_id_2_i,
   output logic                 start_ready_o,
   output logic                 err_o,
   output logic                 busy_o,
   input  logic [2*IQ_DW-1:0]   s_axis_pbch_tdata,
   input  logic                 s_axis_pbch_tvalid,
   output logic                 s_axis_pbch_tready,
   output logic [2*IQ_DW-1:0]   m_axis_out_tdata,
   output logic [1:0]           m_axis_out_tuser,
   output logic                 m_axis_out_tlast,
   output logic                 m_axis_out_tvalid,
   input  logic                 m_axis_out_tready
);
   localparam int KW = $clog2(FFT_LEN);
   localparam logic [KW-1:0] OFF_K = KW'((FFT_LEN - SSB_SC) / 2);
   localparam logic [KW-1:0] END_K = KW'((FFT_LEN + SSB_SC) / 2);
   localparam logic [KW-1:0] KMAX = '1;
   localparam logic [IQ_DW-1:0] AMP_P = IQ_DW'(AMP);
   localparam logic [IQ_DW-1:0] AMP_N = IQ_DW'(-AMP);
   state_t st;
   logic [8:0] n1;
   logic [1:0] n2, l, q;
   logic [KW-1:0] k;
   logic [7:0] s;
   logic [6:0] m_pss, m0, m1;
   logic done, id_ok, in_ssb, in_sync, is_pss, is_sss, is_pbch, pbch_re, pbch_ok;
   logic walk, out_load, adv, pss_b, sss_b;
   logic [IQ_DW-1:0] sync_i;
   logic [2*IQ_DW-1:0] re;
   assign id_ok = N_id_2_i <= 2'd2 && N_id_1_i <= N_ID_1_MAX;
   assign start_ready_o = st == ST_IDLE;
   assign busy_o = st != ST_IDLE;
   // offsets derived with compares instead of a divider
   assign q = n1 >= 9'd224 ? 2'd2 : n1 >= 9'd112 ? 2'd1 : 2'd0;
   assign m_pss = n2 == 2'd2 ? 7'd86 : n2 == 2'd1 ? 7'd43 : 7'd0;
   assign m0 = (q == 2'd2 ? 7'd30 : q == 2'd1 ? 7'd15 : 7'd0) + (n2 == 2'd2 ? 7'd10 : n2 == 2'd1 ? 7'd5 : 7'd0);
   assign m1 = 7'(n1 - (q == 2'd2 ? 9'd224 : q == 2'd1 ? 9'd112 : 9'd0));
   assign in_ssb = k >= OFF_K && k < END_K;
   assign s = 8'(k - OFF_K);
   assign in_sync = s >= PSS_START && s < GAP1_LO;
   assign is_pss = in_ssb && l == 2'd0 && in_sync;
   assign is_sss = in_ssb && l == 2'd2 && in_sync;
   assign is_pbch = in_ssb && (l[0] || (l == 2'd2 && (s < GAP0_LO || s >= GAP1_HI)));
`ifdef SSB_TX_PBCH_EN
   assign pbch_re = is_pbch;
   assign pbch_ok = s_axis_pbch_tvalid;
`else
   logic unused_pbch;
   assign unused_pbch = s_axis_pbch_tvalid ^ is_pbch;
   assign pbch_re = 1'b0;
   assign pbch_ok = 1'b1;
`endif
   // SETUP also emits k=0, which always lies left of the SSB band
   assign walk = st == ST_SETUP || (st == ST_EMIT && !done);
   assign out_load = !m_axis_out_tvalid || m_axis_out_tready;
   assign adv = walk && out_load && (!pbch_re || pbch_ok);
   assign s_axis_pbch_tready = walk && pbch_re && out_load;
   assign sync_i = (is_pss ? pss_b : sss_b) ? AMP_N : AMP_P;
   assign re = pbch_re ? s_axis_pbch_tdata : (is_pss || is_sss) ? {{IQ_DW{1'b0}}, sync_i} : '0;
   ssb_seq_gen u_seq (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .load_i     (st == ST_SETUP),
      .step_pss_i (adv && is_pss),
      .step_sss_i (adv && is_sss),
      .m_pss_i    (m_pss),
      .m0_i       (m0),
      .m1_i       (m1),
      .pss_o      (pss_b),
      .sss_o      (sss_b)
   );
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         st <= ST_IDLE;
         n1 <= '0;
         n2 <= '0;
         l <= '0;
         k <= '0;
         done <= 1'b0;
         err_o <= 1'b0;
         m_axis_out_tvalid <= 1'b0;
         m_axis_out_tdata <= '0;
         m_axis_out_tuser <= '0;
         m_axis_out_tlast <= 1'b0;
      end else begin
         err_o <= st == ST_IDLE && start_i && !id_ok;
         if (st == ST_IDLE && start_i && id_ok) begin
            st <= ST_SETUP;
            n1 <= N_id_1_i;
            n2 <= N_id_2_i;
            l <= '0;
            k <= '0;
            done <= 1'b0;
         end
         if (st == ST_SETUP) st <= ST_EMIT;
         if (st == ST_EMIT && done && out_load) st <= ST_IDLE;
         if (out_load) m_axis_out_tvalid <= adv;
         if (adv) begin
            m_axis_out_tdata <= re;
            m_axis_out_tuser <= l;
            m_axis_out_tlast <= k == KMAX;
            k <= k + KW'(1);
            if (k == KMAX) begin
               l <= l + 2'd1;
               done <= l == 2'd3;
            end
         end
      end
   end
endmodule

// File: tb/tb_ssb_tx_mapper.sv
// tb_ssb_tx_mapper: directed full-SSB runs against an independent sequence model, plus reject/reset sequences.
module tb_ssb_tx_mapper;
   localparam int IQ_DW = 16;
   localparam int FFT_LEN = 256;
   localparam int AMP = 8192;
   localparam int NB = 4 * FFT_LEN;
`ifdef SSB_TX_PBCH_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif
   typedef struct {int n1; int n2; bit rnd; bit poke;} run_t;
   typedef struct {int beat; logic [31:0] d; bit last;} spot_t;
   logic clk_i = 1'b0, reset_ni = 1'b0, start_i = 1'b0;
   logic [8:0] N_id_1_i = '0;
   logic [1:0] N_id_2_i = '0;
   logic start_ready_o, err_o, busy_o;
   logic [31:0] s_axis_pbch_tdata = '0;
   logic s_axis_pbch_tvalid = 1'b0;
   logic s_axis_pbch_tready;
   logic [31:0] m_axis_out_tdata;
   logic [1:0] m_axis_out_tuser;
   logic m_axis_out_tlast, m_axis_out_tvalid;
   logic m_axis_out_tready = 1'b0;
   int xp[127], x0[127], x1[127];
   logic [31:0] cap_d[NB];
   logic [1:0] cap_u[NB];
   logic cap_l[NB];
   int nb, np, nstab, nerr, first_v, last_v;
   bit lat_ok, done_ok;
   int nvec = 0, nmis = 0;

   ssb_tx_mapper #(.IQ_DW(IQ_DW), .FFT_LEN(FFT_LEN), .AMP(AMP)) dut (
      .clk_i(clk_i), .reset_ni(reset_ni), .start_i(start_i),
      .N_id_1_i(N_id_1_i), .N_id_2_i(N_id_2_i),
      .start_ready_o(start_ready_o), .err_o(err_o), .busy_o(busy_o),
      .s_axis_pbch_tdata(s_axis_pbch_tdata), .s_axis_pbch_tvalid(s_axis_pbch_tvalid),
      .s_axis_pbch_tready(s_axis_pbch_tready),
      .m_axis_out_tdata(m_axis_out_tdata), .m_axis_out_tuser(m_axis_out_tuser),
      .m_axis_out_tlast(m_axis_out_tlast), .m_axis_out_tvalid(m_axis_out_tvalid),
      .m_axis_out_tready(m_axis_out_tready)
   );

   always #5 clk_i = ~clk_i;

   function automatic logic [31:0] pbch_word(int p);
      return {16'(16'h4000 + p), 16'(3 * p + 1)};
   endfunction

   // 0 zero, 1 PSS, 2 SSS, 3 PBCH
   function automatic int region(int l, int k);
      int s;
      s = k - (FFT_LEN - 240) / 2;
      if (s < 0 || s > 239) return 0;
      if (l == 1 || l == 3) return 3;
      if (s >= 56 && s <= 182) return l == 0 ? 1 : l == 2 ? 2 : 0;
      if (l == 2 && (s <= 47 || s >= 192)) return 3;
      return 0;
   endfunction

   function automatic logic [31:0] bpsk(int d);
      return {16'd0, d > 0 ? 16'(AMP) : 16'(-AMP)};
   endfunction

   function automatic logic [31:0] model(int n1, int n2, int l, int k, int p);
      int n, rg;
      n = k - (FFT_LEN - 240) / 2 - 56;
      rg = region(l, k);
      if (rg == 1) return bpsk(1 - 2 * xp[(n + (43 * n2) % 127) % 127]);
      if (rg == 2) return bpsk((1 - 2 * x0[(n + 15 * (n1 / 112) + 5 * n2) % 127]) * (1 - 2 * x1[(n + n1 % 112) % 127]));
      if (rg == 3) return PE ? pbch_word(p) : 32'd0;
      return 32'd0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic run_ssb(input int n1, input int n2, input bit rnd, input bit poke);
      logic [34:0] hold;
      bit holding;
      int cyc;
      nb = 0; np = 0; nstab = 0; nerr = 0; first_v = -1; last_v = -1; holding = 0; cyc = 0; hold = '0;
      for (int i = 0; i < NB; i++) cap_d[i] = 'x;
      start_i = 1'b1; N_id_1_i = 9'(n1); N_id_2_i = 2'(n2);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      lat_ok = busy_o && !start_ready_o && !m_axis_out_tvalid;
      while (nb < NB && cyc < 20000) begin
         m_axis_out_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         s_axis_pbch_tvalid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
         s_axis_pbch_tdata = pbch_word(np);
         start_i = poke && cyc >= 100 && cyc < 104;
         if (start_i) begin N_id_1_i = 9'd7; N_id_2_i = 2'd0; end
         @(negedge clk_i);
         if (err_o) nerr++;
         if (holding && (!m_axis_out_tvalid || {m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tlast} != hold)) nstab++;
         holding = m_axis_out_tvalid && !m_axis_out_tready;
         hold = {m_axis_out_tdata, m_axis_out_tuser, m_axis_out_tlast};
         if (m_axis_out_tvalid && first_v < 0) first_v = cyc;
         if (m_axis_out_tvalid && m_axis_out_tready) begin
            cap_d[nb] = m_axis_out_tdata; cap_u[nb] = m_axis_out_tuser; cap_l[nb] = m_axis_out_tlast;
            last_v = cyc; nb++;
         end
         if (s_axis_pbch_tvalid && s_axis_pbch_tready) np++;
         @(posedge clk_i); #1;
         cyc++;
      end
      start_i = 1'b0;
      s_axis_pbch_tvalid = 1'b0;
      done_ok = !busy_o && start_ready_o;
   endtask

   task automatic check_run(input run_t r);
      int p = 0, bd = 0, bu = 0, bl = 0;
      for (int l = 0; l < 4; l++)
         for (int k = 0; k < FFT_LEN; k++) begin
            if (cap_d[l * FFT_LEN + k] !== model(r.n1, r.n2, l, k, p)) bd++;
            if (cap_u[l * FFT_LEN + k] !== 2'(l)) bu++;
            if (cap_l[l * FFT_LEN + k] !== (k == FFT_LEN - 1)) bl++;
            if (region(l, k) == 3) p++;
         end
      chk("beat count", nb, NB);
      chk("data beats wrong", bd, 0);
      chk("tuser beats wrong", bu, 0);
      chk("tlast beats wrong", bl, 0);
      chk("pbch handshakes", np, PE ? 576 : 0);
      chk("held while stalled", nstab, 0);
      chk("no err during run", nerr, 0);
      chk("start latency", {lat_ok, first_v == 1}, 2'b11);
      chk("completion ready", done_ok, 1);
      if (!r.rnd) chk("unstalled last beat cycle", last_v, NB);
   endtask

   task automatic reject(input int n1, input int n2);
      int nv = 0;
      start_i = 1'b1; N_id_1_i = 9'(n1); N_id_2_i = 2'(n2);
      @(posedge clk_i); #1;
      start_i = 1'b0;
      chk("reject err/busy/ready", {err_o, busy_o, start_ready_o}, 3'b101);
      @(posedge clk_i); #1;
      chk("reject err one cycle", err_o, 0);
      m_axis_out_tready = 1'b1;
      repeat (20) begin
         if (m_axis_out_tvalid || busy_o) nv++;
         @(posedge clk_i); #1;
      end
      chk("reject no beats", nv, 0);
   endtask

   initial begin
      run_t runs[4];
      spot_t spots[13];
      run_t rr;
      xp[0:6] = '{0, 1, 1, 0, 1, 1, 1};
      x0[0:6] = '{1, 0, 0, 0, 0, 0, 0};
      x1[0:6] = '{1, 0, 0, 0, 0, 0, 0};
      for (int i = 0; i < 120; i++) begin
         xp[i + 7] = xp[i + 4] ^ xp[i];
         x0[i + 7] = x0[i + 4] ^ x0[i];
         x1[i + 7] = x1[i + 1] ^ x1[i];
      end
      runs[0] = '{0, 0, 1'b0, 1'b0};
      runs[1] = '{335, 2, 1'b0, 1'b0};
      runs[2] = '{335, 2, 1'b1, 1'b0};
      runs[3] = '{150, 1, 1'b1, 1'b1};
      spots[0] = '{0, 32'h0, 1'b0};
      spots[1] = '{63, 32'h0, 1'b0};
      spots[2] = '{64, 32'h0000_2000, 1'b0};
      spots[3] = '{65, 32'h0000_E000, 1'b0};
      spots[4] = '{246, 32'h0, 1'b0};
      spots[5] = '{255, 32'h0, 1'b1};
      spots[6] = '{512, 32'h0, 1'b0};
      spots[7] = '{520, PE ? pbch_word(240) : 32'h0, 1'b0};
      spots[8] = '{567, PE ? pbch_word(287) : 32'h0, 1'b0};
      spots[9] = '{568, 32'h0, 1'b0};
      spots[10] = '{576, 32'h0000_2000, 1'b0};
      spots[11] = '{577, 32'h0000_2000, 1'b0};
      spots[12] = '{712, PE ? pbch_word(288) : 32'h0, 1'b0};
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset outputs", {start_ready_o, err_o, busy_o, s_axis_pbch_tready, m_axis_out_tvalid, m_axis_out_tlast, m_axis_out_tdata, m_axis_out_tuser}, {6'b100000, 34'd0});
      reset_ni = 1'b1;
      @(posedge clk_i); #1;
      reject(336, 0);
      reject(0, 3);
      for (int i = 0; i < 4; i++) begin
         run_ssb(runs[i].n1, runs[i].n2, runs[i].rnd, runs[i].poke);
         check_run(runs[i]);
         if (i == 0)
            foreach (spots[j]) chk($sformatf("beat %0d", spots[j].beat), {cap_l[spots[j].beat], cap_d[spots[j].beat]}, {spots[j].last, spots[j].d});
      end
      start_i = 1'b1; N_id_1_i = 9'd10; N_id_2_i = 2'd1;
      m_axis_out_tready = 1'b1; s_axis_pbch_tvalid = 1'b1; s_axis_pbch_tdata = 32'h1234_5678;
      @(posedge clk_i); #1;
      start_i = 1'b0;
      repeat (300) @(posedge clk_i);
      #1;
      chk("mid symbol 1 before reset", {m_axis_out_tvalid, m_axis_out_tuser}, 3'b101);
      #2 reset_ni = 1'b0;
      s_axis_pbch_tvalid = 1'b0;
      @(posedge clk_i); #1;
      chk("reset mid-SSB outputs", {start_ready_o, err_o, busy_o, s_axis_pbch_tready, m_axis_out_tvalid, m_axis_out_tlast, m_axis_out_tdata, m_axis_out_tuser}, {6'b100000, 34'd0});
      reset_ni = 1'b1;
      @(posedge clk_i); #1;
      rr = '{200, 1, 1'b0, 1'b0};
      run_ssb(rr.n1, rr.n2, rr.rnd, rr.poke);
      check_run(rr);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end
endmodule
